// File: rtl/instruction_fetch.sv
// Fetch stage of the pipelined MIPS core: owns the PC, reads the 128-entry
// instruction memory and loads the IF/ID pipeline register.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_WORDS = 128,
    parameter int          AW       = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] im_addr,
    input  logic [31:0]   im_data,
    input  logic          stall,
    input  logic          flush,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          jump,
    input  logic [25:0]   jump_index,
    output logic [31:0]   pc,
    output logic [31:0]   if_id_instr,
    output logic [31:0]   if_id_pc4,
    output logic          if_id_valid,
    output logic          halted
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    localparam logic [31:0] PC_LIMIT = 32'(IM_WORDS * 4);

    state_t      state;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] br_target;

    assign im_addr     = pc[AW+1:2];
    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {if_id_pc4[31:28], jump_index, 2'b00};
    assign br_target   = branch_target & 32'hFFFF_FFFC;

    // Branch outranks jump because the branch in EX is the older instruction;
    // a bubble leaves if_id_pc4 untouched so a pending jump still sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        pc          <= br_target;
                        if_id_instr <= '0;
                        if_id_valid <= 1'b0;
                    end else if (jump) begin
                        pc          <= jump_target;
                        if_id_instr <= '0;
                        if_id_valid <= 1'b0;
                    end else if (pc >= PC_LIMIT) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        if_id_instr <= '0;
                        if_id_valid <= 1'b0;
                    end else if (stall) begin
                        if (flush) begin
                            if_id_instr <= '0;
                            if_id_valid <= 1'b0;
                        end
                    end else if (flush) begin
                        pc          <= pc_plus4;
                        if_id_instr <= '0;
                        if_id_valid <= 1'b0;
                    end else begin
                        pc          <= pc_plus4;
                        if_id_instr <= im_data;
                        if_id_pc4   <= pc_plus4;
                        if_id_valid <= 1'b1;
                    end
                end
                HALT: begin
                    if_id_instr <= '0;
                    if_id_valid <= 1'b0;
                    if (branch_taken) begin
                        pc     <= br_target;
                        state  <= RUN;
                        halted <= 1'b0;
                    end else if (jump) begin
                        pc     <= jump_target;
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed vector bench for instruction_fetch with a combinational
// instruction-memory model holding distinct nonzero words.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [6:0]  im_addr;
    logic [31:0] im_data;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] mem [128];

    int vectorsApplied = 0;
    int miscompares    = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] brTgt;
        logic        jmp;
        logic [25:0] jIdx;
        logic [31:0] ePc;
        logic [31:0] eInstr;
        logic [31:0] ePc4;
        logic        eValid;
        logic        eHalted;
    } vec_t;

    vec_t vecs [31];

    instruction_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .im_addr      (im_addr),
        .im_data      (im_data),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .pc           (pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    assign im_data = mem[im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic vec_t mk(input logic s, input logic f, input logic b,
                                input logic [31:0] bt, input logic j,
                                input logic [25:0] ji, input logic [31:0] epc,
                                input logic [31:0] ei, input logic [31:0] ep4,
                                input logic ev, input logic eh);
        vec_t v;
        v.stall = s; v.flush = f; v.br = b; v.brTgt = bt; v.jmp = j; v.jIdx = ji;
        v.ePc = epc; v.eInstr = ei; v.ePc4 = ep4; v.eValid = ev; v.eHalted = eh;
        return v;
    endfunction

    function automatic vec_t idle(input logic [31:0] epc, input logic [31:0] ei,
                                  input logic [31:0] ep4, input logic ev,
                                  input logic eh);
        return mk(0, 0, 0, 32'h0, 0, 26'h0, epc, ei, ep4, ev, eh);
    endfunction

    task automatic applyStimulus(input vec_t v);
        stall         = v.stall;
        flush         = v.flush;
        branch_taken  = v.br;
        branch_target = v.brTgt;
        jump          = v.jmp;
        jump_index    = v.jIdx;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s %s got %h expected %h", name, field, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        vectorsApplied++;
        cmp(name, "pc", pc, v.ePc);
        cmp(name, "im_addr", {25'h0, im_addr}, {25'h0, v.ePc[8:2]});
        cmp(name, "if_id_instr", if_id_instr, v.eInstr);
        cmp(name, "if_id_pc4", if_id_pc4, v.ePc4);
        cmp(name, "if_id_valid", {31'h0, if_id_valid}, {31'h0, v.eValid});
        cmp(name, "halted", {31'h0, halted}, {31'h0, v.eHalted});
    endtask

    initial begin
        vec_t rv;
        for (int i = 0; i < 128; i++) mem[i] = w(i);

        vecs[0]  = idle(32'h04, w(0), 32'h04, 1, 0);
        vecs[1]  = idle(32'h08, w(1), 32'h08, 1, 0);
        vecs[2]  = mk(1, 0, 0, 32'h0, 0, 26'h0, 32'h08, w(1), 32'h08, 1, 0);
        vecs[3]  = mk(1, 0, 0, 32'h0, 0, 26'h0, 32'h08, w(1), 32'h08, 1, 0);
        vecs[4]  = idle(32'h0C, w(2), 32'h0C, 1, 0);
        vecs[5]  = idle(32'h10, w(3), 32'h10, 1, 0);
        vecs[6]  = mk(0, 0, 1, 32'h0C, 1, 26'd5, 32'h0C, 32'h0, 32'h10, 0, 0);
        vecs[7]  = idle(32'h10, w(3), 32'h10, 1, 0);
        vecs[8]  = idle(32'h14, w(4), 32'h14, 1, 0);
        vecs[9]  = idle(32'h18, w(5), 32'h18, 1, 0);
        vecs[10] = idle(32'h1C, w(6), 32'h1C, 1, 0);
        vecs[11] = idle(32'h20, w(7), 32'h20, 1, 0);
        vecs[12] = idle(32'h24, w(8), 32'h24, 1, 0);
        vecs[13] = mk(0, 0, 0, 32'h0, 1, 26'd13, 32'h34, 32'h0, 32'h24, 0, 0);
        vecs[14] = idle(32'h38, w(13), 32'h38, 1, 0);
        vecs[15] = mk(1, 1, 0, 32'h0, 0, 26'h0, 32'h38, 32'h0, 32'h38, 0, 0);
        vecs[16] = mk(0, 1, 0, 32'h0, 0, 26'h0, 32'h3C, 32'h0, 32'h38, 0, 0);
        vecs[17] = idle(32'h40, w(15), 32'h40, 1, 0);
        vecs[18] = mk(1, 0, 1, 32'h1FB, 0, 26'h0, 32'h1F8, 32'h0, 32'h40, 0, 0);
        vecs[19] = idle(32'h1FC, w(126), 32'h1FC, 1, 0);
        vecs[20] = idle(32'h200, w(127), 32'h200, 1, 0);
        vecs[21] = idle(32'h200, 32'h0, 32'h200, 0, 1);
        vecs[22] = idle(32'h200, 32'h0, 32'h200, 0, 1);
        vecs[23] = mk(1, 0, 0, 32'h0, 0, 26'h0, 32'h200, 32'h0, 32'h200, 0, 1);
        vecs[24] = mk(0, 0, 1, 32'h0, 0, 26'h0, 32'h0, 32'h0, 32'h200, 0, 0);
        vecs[25] = idle(32'h04, w(0), 32'h04, 1, 0);
        vecs[26] = mk(0, 0, 1, 32'h1FC, 0, 26'h0, 32'h1FC, 32'h0, 32'h04, 0, 0);
        vecs[27] = idle(32'h200, w(127), 32'h200, 1, 0);
        vecs[28] = idle(32'h200, 32'h0, 32'h200, 0, 1);
        vecs[29] = mk(0, 0, 0, 32'h0, 1, 26'd2, 32'h08, 32'h0, 32'h200, 0, 0);
        vecs[30] = idle(32'h0C, w(2), 32'h0C, 1, 0);

        rst_n = 1'b0;
        stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jump_index = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", idle(32'h0, 32'h0, 32'h0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Free-run from 0x0C up to pc=0x40 with a valid instruction in IF/ID.
        for (int k = 0; k < 13; k++) begin
            rv = idle(32'h10 + 32'(4 * k), w(3 + k), 32'h10 + 32'(4 * k), 1, 0);
            applyStimulus(rv);
            checkOutput($sformatf("run%0d", k), rv);
        end

        // Asynchronous reset dropped between edges must clear outputs at once.
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst_now", idle(32'h0, 32'h0, 32'h0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("async_rst_held", idle(32'h0, 32'h0, 32'h0, 0, 0));
        rst_n = 1'b1;
        rv = idle(32'h04, w(0), 32'h04, 1, 0);
        applyStimulus(rv);
        checkOutput("restart0", rv);
        rv = idle(32'h08, w(1), 32'h08, 1, 0);
        applyStimulus(rv);
        checkOutput("restart1", rv);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the pipelined MIPS core: the read-side initiator for the 128-entry instruction memory.
- Owns the PC and drives the word address to instruction memory, which returns a 32-bit word combinationally in the same cycle.
- Registers the returned word and PC+4 into the IF/ID pipeline register.
- Handles stall, flush, branch and jump redirects, and a halt when the PC runs past the end of memory.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IM_WORDS, 128, number of instruction-memory entries; fetch halts at PC >= IM_WORDS*4.
- AW, 7, instruction-memory word-address width, equal to log2(IM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- im_addr  out  AW  word address to instruction memory, equal to pc[AW+1:2].
- im_data  in  32  instruction word from memory, valid in the same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  replace the IF/ID contents with a bubble.
- branch_taken  in  1  EX stage: branch resolved taken.
- branch_target  in  32  EX stage: branch byte address.
- jump  in  1  ID stage: J-type jump decoded.
- jump_index  in  26  ID stage: instr[25:0].
- pc  out  32  current fetch PC (byte address).
- if_id_instr  out  32  registered instruction.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped after running past the end of memory.

Behaviour:
Clock and reset:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0: pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, state=RUN.
- Reset takes effect immediately, mid-cycle and mid-operation included; no redirect survives it.
- The first rising edge after release registers mem[RESET_PC>>2].

State machine:
- RUN -> HALT at an edge where there is no redirect and pc >= IM_WORDS*4.
- In HALT: PC holds, the IF/ID register loads a bubble every cycle, and halted=1.
- HALT -> RUN on branch_taken or jump; the PC loads the target in that same edge.

Address and targets:
- im_addr = pc[AW+1:2]. The memory's combinational read makes fetch latency one edge.
- Jump target = {pc4_id[31:28], jump_index, 2'b00}, where pc4_id = if_id_pc4.
- Branch target = branch_target with bits [1:0] forced to 0.
- All PC arithmetic is 32-bit unsigned; wrap at 2^32 is ignored.

Per-edge priority, RUN state:
1. branch_taken: pc <- branch target; IF/ID <- bubble. A simultaneous jump is ignored because the branch is the older instruction.
2. jump: pc <- jump target; IF/ID <- bubble.
3. stall: pc and the IF/ID register hold. If flush is also asserted, the IF/ID register loads a bubble instead.
4. flush alone: pc <- pc+4; IF/ID <- bubble.
5. Otherwise: pc <- pc+4; if_id_instr <- im_data; if_id_pc4 <- pc+4; if_id_valid <- 1.

Additional rules:
- A redirect always overrides stall for the PC.
- Bubble means if_id_instr=32'h0000_0000 (sll $0 nop), if_id_valid=0, and if_id_pc4 unchanged.
- When the PC is in range, fetch never reads past the last entry: address (IM_WORDS-1)*4 fetches normally.
- Next cycle, PC = IM_WORDS*4 and the machine enters HALT unless a redirect is present.

Test Plan:
- Reset, then 4 free-running cycles with memory words W0..W3:
  - if_id_instr goes W0, W1, W2, W3.
  - if_id_pc4 goes 4, 8, 12, 16.
  - pc=16.
  - valid=1 from the 1st edge.
- With pc=8, hold stall for 2 cycles: pc stays 8 and IF/ID keeps the word at 4 with pc4=8. Release stall: the next edge registers mem[2] with pc4=12.
- Assert branch_taken with branch_target=0x0C and jump=1 in the same cycle:
  - pc=0x0C.
  - IF/ID is a bubble (instr=0, valid=0).
  - The next edge registers mem[3].
- jump=1 with jump_index=13 and if_id_pc4=0x24: pc=0x34 and IF/ID is a bubble. Then assert stall+flush together: pc holds and IF/ID is a bubble.
- Free-run from pc=0x1F8:
  - mem[126] and mem[127] are fetched.
  - pc reaches 0x200 and the block enters HALT; halted=1 and valid=0 on every following edge.
  - branch_taken with target 0 returns to RUN, halted=0 and pc=0.
- Drop rst_n asynchronously between edges while pc=0x40 and valid=1: all outputs return to reset values immediately, and after release fetch restarts at mem[0].
